// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one 128-bit block memory port between the instruction cache
//   (read-only) and the data cache (block read for allocate, block write for
//   write-back). Each cache keeps its own mem_* style handshake unchanged.
//   Grants are round-robin. Only one transaction is in flight at a time, and
//   every completion is followed by a single release cycle.
//
// Handshake (both cache sides and the memory side):
//   A cache raises x_read / x_write with a stable address (and write data)
//   and holds it until it sees x_ready. x_ready is a one-cycle pulse that is
//   combinationally equal to mem_ready while that cache's transaction owns
//   the port. x_rdata is only meaningful in the cycle where x_ready is 1.
//   Toward memory, mem_read / mem_write / mem_addr / mem_wdata are registered
//   and stay stable from the cycle after the grant until mem_ready pulses.
//
// Ports:
//   clk, proc_reset_n          clock, synchronous active-low reset
//   i_read, i_addr             I-cache block read request
//   i_rdata, i_ready           I-cache read data / done pulse
//   d_read, d_write, d_addr,   D-cache block read / write-back request
//   d_wdata
//   d_rdata, d_ready           D-cache read data / done pulse
//   mem_read, mem_write,       command toward memory (registered)
//   mem_addr, mem_wdata
//   mem_rdata, mem_ready       memory read data / one-cycle done pulse
//   o_dbg_state                current FSM state (IDLE=0, BUSY_I=1,
//                              BUSY_D=2, REL=3)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // debug
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    REL    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_last_d;     // 1: last grant went to D, 0: to I
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;
  logic w_grant_i;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // On a tie the side that did not win last time is served. last_grant resets
  // to I, so the first tie after reset goes to D.
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);
  assign w_grant_i = w_i_req & ~w_grant_d;

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_last_d    <= 1'b1;
            // read and write together is an error case; treated as a write
            r_mem_write <= d_write;
            r_mem_read  <= ~d_write;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
          end else if (w_grant_i) begin
            r_state     <= BUSY_I;
            r_last_d    <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= i_addr;
          end
        end
        BUSY_I, BUSY_D: begin
          // Requests may drop while busy; the transaction still runs to
          // completion because the command is held in the latched registers.
          if (mem_ready) begin
            r_state     <= REL;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        REL: begin
          // Caches register their ready, so the finished requester still
          // shows its request during this cycle. Ignoring all requests here
          // keeps that stale request from starting a duplicate transaction.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Ready is only forwarded to the cache that owns the port; mem_ready seen
  // in IDLE or REL is dropped.
  assign i_ready = (r_state == BUSY_I) & mem_ready;
  assign d_ready = (r_state == BUSY_D) & mem_ready;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign o_dbg_state = r_state;

  // The port never carries a read and a write at the same time.
  a_no_rd_wr: assert property (@(posedge clk) !(r_mem_read && r_mem_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  // ---------------------------------------------------------------- clock/reset
  logic              clk = 1'b0;
  logic              proc_reset_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [1:0]        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .i_read       (i_read),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_ready      (i_ready),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_ready      (d_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .o_dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------- driver tasks
  // Advance to just after the next rising edge; inputs change and registered
  // outputs are sampled here, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read    = 1'b0;
    i_addr    = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    proc_reset_n = 1'b0;
    clear_inputs();
    step();
    step();
    proc_reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    proc_reset_n = 1'b0;
    clear_inputs();
    // requests and a stray mem_ready during reset must not leak through
    i_read = 1'b1; d_write = 1'b1; d_addr = 28'hFFFFFFF; d_wdata = '1;
    mem_ready = 1'b1;
    step();
    step();
    #1;
    n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read got=%0b exp=0", mem_read); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mem_write got=%0b exp=0", mem_write); end
    n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0) begin n_err++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    n_cmp++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got i=%0b d=%0b exp=0/0", i_ready, d_ready); end
    clear_inputs();
    proc_reset_n = 1'b1;
    step();
    // mem_ready in IDLE is ignored
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready got i=%0b d=%0b exp=0/0", i_ready, d_ready); end
    step();
    mem_ready = 1'b0;
    n_cmp++; if (mem_read !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL idle_stay got rd=%0b st=%0d exp=0/0", mem_read, dbg_state); end
  endtask

  task automatic test_d_read();
    // cycle 1: request
    d_read = 1'b1; d_addr = 28'h0000010;
    for (int c = 2; c <= 4; c++) begin
      step();
      n_cmp++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000010) begin
        n_err++; $display("FAIL dread_cmd cyc%0d got rd=%0b wr=%0b a=%h exp=1/0/0000010", c, mem_read, mem_write, mem_addr);
      end
      n_cmp++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL dread_early_ready cyc%0d got=%0b exp=0", c, d_ready); end
    end
    step();  // cycle 5
    mem_ready = 1'b1; mem_rdata = {16{8'hA5}};
    #1;
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000010) begin n_err++; $display("FAIL dread_cmd cyc5 got rd=%0b a=%h exp=1/0000010", mem_read, mem_addr); end
    n_cmp++; if (d_ready !== 1'b1 || d_rdata !== {16{8'hA5}}) begin n_err++; $display("FAIL dread_done got rdy=%0b data=%h exp=1/a5..a5", d_ready, d_rdata); end
    n_cmp++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL dread_i_ready got=%0b exp=0", i_ready); end
    step();  // cycle 6: REL, d_read still held by the cache
    mem_ready = 1'b0;
    n_cmp++; if (mem_read !== 1'b0 || dbg_state !== 2'd3) begin n_err++; $display("FAIL dread_rel got rd=%0b st=%0d exp=0/3", mem_read, dbg_state); end
    d_read = 1'b0;
    step();
    n_cmp++; if (mem_read !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL dread_idle got rd=%0b st=%0d exp=0/0", mem_read, dbg_state); end
  endtask

  task automatic test_writeback_alloc();
    d_write = 1'b1; d_addr = 28'h0000123; d_wdata = 128'h1;
    step();
    n_cmp++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h0000123 || mem_wdata !== 128'h1) begin
      n_err++; $display("FAIL wb_cmd got wr=%0b rd=%0b a=%h wd=%h exp=1/0/0000123/1", mem_write, mem_read, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL wb_ready got=%0b exp=1", d_ready); end
    step();  // REL: cache already switches to its allocate read
    mem_ready = 1'b0;
    d_write = 1'b0; d_read = 1'b1; d_addr = 28'h0000456;
    n_cmp++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || dbg_state !== 2'd3) begin
      n_err++; $display("FAIL wb_rel got wr=%0b rd=%0b st=%0d exp=0/0/3", mem_write, mem_read, dbg_state);
    end
    step();  // IDLE: request sampled at the end of this cycle
    n_cmp++; if (mem_read !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL wb_idle got rd=%0b st=%0d exp=0/0", mem_read, dbg_state); end
    step();
    n_cmp++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000456) begin
      n_err++; $display("FAIL alloc_cmd got rd=%0b wr=%0b a=%h exp=1/0/0000456", mem_read, mem_write, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    #1;
    n_cmp++; if (d_ready !== 1'b1 || d_rdata !== 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677) begin
      n_err++; $display("FAIL alloc_done got rdy=%0b data=%h", d_ready, d_rdata);
    end
    step();
    mem_ready = 1'b0;
    d_read = 1'b0;
    step();
  endtask

  task automatic test_hold_past_ready();
    i_read = 1'b1; i_addr = 28'h0000077;
    step();
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000077) begin n_err++; $display("FAIL hold_cmd got rd=%0b a=%h exp=1/0000077", mem_read, mem_addr); end
    mem_ready = 1'b1; mem_rdata = {4{32'hDEADBEEF}};
    #1;
    n_cmp++; if (i_ready !== 1'b1 || i_rdata !== {4{32'hDEADBEEF}} || d_ready !== 1'b0) begin
      n_err++; $display("FAIL hold_done got irdy=%0b drdy=%0b data=%h", i_ready, d_ready, i_rdata);
    end
    step();  // REL with i_read still high
    mem_ready = 1'b0;
    step();
    i_read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (mem_read !== 1'b0 || i_ready !== 1'b0) begin n_err++; $display("FAIL hold_dup c%0d got rd=%0b rdy=%0b exp=0/0", c, mem_read, i_ready); end
      step();
    end
  endtask

  task automatic test_rd_wr_both();
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000ABC; d_wdata = {4{32'h5555AAAA}};
    step();
    n_cmp++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== {4{32'h5555AAAA}}) begin
      n_err++; $display("FAIL both_cmd got wr=%0b rd=%0b wd=%h exp=1/0", mem_write, mem_read, mem_wdata);
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL both_ready got=%0b exp=1", d_ready); end
    step();
    mem_ready = 1'b0; d_read = 1'b0; d_write = 1'b0;
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL both_deassert got=%0b exp=0", mem_write); end
    step();
  endtask

  task automatic test_drop_during_busy();
    i_read = 1'b1; i_addr = 28'h0000200;
    step();
    i_read = 1'b0;
    step();
    step();
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000200) begin n_err++; $display("FAIL drop_hold got rd=%0b a=%h exp=1/0000200", mem_read, mem_addr); end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready got=%0b exp=1", i_ready); end
    step();
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_in_busy();
    d_read = 1'b1; d_addr = 28'h0000300;
    step();  // BUSY_D cycle 1
    step();  // BUSY_D cycle 2
    proc_reset_n = 1'b0;
    step();
    n_cmp++; if (mem_read !== 1'b0 || dbg_state !== 2'd0 || mem_addr !== '0) begin
      n_err++; $display("FAIL rbusy_abort got rd=%0b st=%0d a=%h exp=0/0/0", mem_read, dbg_state, mem_addr);
    end
    proc_reset_n = 1'b1;
    d_read = 1'b0;
    // a late memory completion for the aborted transaction
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL rbusy_dready got=%0b exp=0", d_ready); end
    step();
    mem_ready = 1'b0;
    i_read = 1'b1; i_addr = 28'h0000999;
    step();
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000999) begin n_err++; $display("FAIL rbusy_after got rd=%0b a=%h exp=1/0000999", mem_read, mem_addr); end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin n_err++; $display("FAIL rbusy_after_rdy got i=%0b d=%0b exp=1/0", i_ready, d_ready); end
    step();
    mem_ready = 1'b0; i_read = 1'b0;
    step();
  endtask

  // Both sides rise together after reset and stay high: D, I, D, I. The gap
  // from one mem_ready to the next mem_read is REL + IDLE.
  task automatic test_round_robin();
    logic exp_d;
    int   waited;
    do_reset();
    i_read = 1'b1; i_addr = 28'h0000111;
    d_read = 1'b1; d_addr = 28'h0000222;
    for (int k = 0; k < 4; k++) begin
      exp_d  = (k % 2 == 0);
      waited = 0;
      step();
      mem_ready = 1'b0;
      while (!mem_read && waited < 8) begin
        step();
        waited++;
      end
      n_cmp++; if (waited !== ((k == 0) ? 0 : 2)) begin n_err++; $display("FAIL rr_gap t%0d got=%0d exp=%0d", k, waited, (k == 0) ? 0 : 2); end
      n_cmp++; if (mem_addr !== (exp_d ? 28'h0000222 : 28'h0000111)) begin n_err++; $display("FAIL rr_order t%0d got a=%h exp_d=%0b", k, mem_addr, exp_d); end
      step();
      mem_ready = 1'b1; mem_rdata = {DATA_W{1'b0}} | 128'(k + 1);
      #1;
      n_cmp++; if (d_ready !== exp_d || i_ready !== !exp_d) begin
        n_err++; $display("FAIL rr_ready t%0d got i=%0b d=%0b exp i=%0b d=%0b", k, i_ready, d_ready, !exp_d, exp_d);
      end
    end
    step();
    clear_inputs();
    step();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    proc_reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_d_read();
    test_writeback_alloc();
    test_hold_past_ready();
    test_rd_wr_both();
    test_drop_during_busy();
    test_reset_in_busy();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=still_running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
